timer_bank: RTL and testbench

//   Parametrised bank of NUM_CH independent HH:MM:SS countdown timers with a shared 1 Hz prescaler.

---
 rtl/timer_bank_if.sv | 28 ++
 rtl/timer_bank.sv | 124 ++++++++++++
 tb/tb_timer_bank.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_bank_if.sv
// Command/status bundle for timer_bank: channel select, one-cycle command pulses
// and the selected channel's time plus per-channel run/alarm flags.
interface timer_bank_if #(
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CW-1:0]     ch_sel;
  logic              start;
  logic              clear;
  logic              hr_inc;
  logic              min_inc;
  logic              sec_inc;
  logic [16:0]       time_out;
  logic [NUM_CH-1:0] running;
  logic [NUM_CH-1:0] alarm;
  logic              any_alarm;

  modport master (
    output ch_sel, start, clear, hr_inc, min_inc, sec_inc,
    input  time_out, running, alarm, any_alarm
  );

  modport slave (
    input  ch_sel, start, clear, hr_inc, min_inc, sec_inc,
    output time_out, running, alarm, any_alarm
  );
endinterface

// File: rtl/timer_bank.sv
// Bank of NUM_CH HH:MM:SS countdown timers sharing one free-running prescaler;
// the channel addressed by ch_sel receives commands and drives time_out.
module timer_bank #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic        clk_100Mhz,
  input  logic        reset_in,
  timer_bank_if.slave bus
);
  localparam int unsigned CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PERIOD = CLK_HZ / TICK_HZ;
  localparam int unsigned PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ALARM} state_e;

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  state_e     state_q [NUM_CH];
  state_e     state_d [NUM_CH];
  logic [4:0] hh_q [NUM_CH];
  logic [4:0] hh_d [NUM_CH];
  logic [5:0] mm_q [NUM_CH];
  logic [5:0] mm_d [NUM_CH];
  logic [5:0] ss_q [NUM_CH];
  logic [5:0] ss_d [NUM_CH];

  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] nonzero;

  assign tick = (pre_q == PW'(PERIOD - 1));

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign sel[g]         = (bus.ch_sel == CW'(g));
    assign nonzero[g]     = (hh_q[g] != '0) || (mm_q[g] != '0) || (ss_q[g] != '0);
    assign bus.running[g] = (state_q[g] == S_RUN);
    assign bus.alarm[g]   = (state_q[g] == S_ALARM);
  end

  assign bus.any_alarm = |bus.alarm;

  always_comb begin
    bus.time_out = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sel[i]) bus.time_out = {hh_q[i], mm_q[i], ss_q[i]};
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      hh_d[i]    = hh_q[i];
      mm_d[i]    = mm_q[i];
      ss_d[i]    = ss_q[i];

      if (sel[i] && bus.clear) begin
        state_d[i] = S_IDLE;
        hh_d[i]    = '0;
        mm_d[i]    = '0;
        ss_d[i]    = '0;
      end else if (sel[i] && bus.start) begin
        // A start on a tick edge consumes that channel's tick.
        case (state_q[i])
          S_IDLE:  if (nonzero[i]) state_d[i] = S_RUN;
          S_RUN:   state_d[i] = S_PAUSE;
          S_PAUSE: state_d[i] = S_RUN;
          S_ALARM: state_d[i] = S_IDLE;
          default: state_d[i] = S_IDLE;
        endcase
      end else begin
        case (state_q[i])
          S_IDLE: begin
            if (sel[i] && bus.hr_inc)  hh_d[i] = (hh_q[i] == 5'd23) ? '0 : hh_q[i] + 1'b1;
            if (sel[i] && bus.min_inc) mm_d[i] = (mm_q[i] == 6'd59) ? '0 : mm_q[i] + 1'b1;
            if (sel[i] && bus.sec_inc) ss_d[i] = (ss_q[i] == 6'd59) ? '0 : ss_q[i] + 1'b1;
          end
          S_RUN: begin
            if (tick) begin
              if (hh_q[i] == '0 && mm_q[i] == '0 && ss_q[i] <= 6'd1) begin
                ss_d[i]    = '0;
                state_d[i] = S_ALARM;
              end else if (ss_q[i] != '0) begin
                ss_d[i] = ss_q[i] - 1'b1;
              end else begin
                ss_d[i] = 6'd59;
                if (mm_q[i] != '0) begin
                  mm_d[i] = mm_q[i] - 1'b1;
                end else begin
                  mm_d[i] = 6'd59;
                  hh_d[i] = hh_q[i] - 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_100Mhz) begin
    if (reset_in) begin
      pre_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        hh_q[i]    <= '0;
        mm_q[i]    <= '0;
        ss_q[i]    <= '0;
      end
    end else begin
      pre_q   <= pre_d;
      state_q <= state_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
    end
  end
endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank with a 10-cycle tick; expectations are queued by
// the stimulus and compared by a negedge monitor.
module tb_timer_bank;
  localparam int unsigned NUM_CH = 4;

  typedef enum int {F_TIME, F_RUN, F_ALARM, F_ANY} field_e;
  typedef enum int {C_START, C_CLEAR, C_HR, C_MIN, C_SEC} cmd_e;
  typedef struct {
    string       name;
    field_e      f;
    logic [16:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total  = 0;
  int   passed = 0;
  int   ph     = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  timer_bank_if #(.NUM_CH(NUM_CH)) bus ();

  timer_bank #(.NUM_CH(NUM_CH), .CLK_HZ(10), .TICK_HZ(1)) dut (
    .clk_100Mhz(clk),
    .reset_in  (rst),
    .bus       (bus)
  );

  // Reference prescaler phase: value the prescaler holds after each edge.
  always @(posedge clk) begin
    if (rst) ph <= 0;
    else     ph <= (ph == 9) ? 0 : ph + 1;
  end

  always @(negedge clk) begin
    exp_t        e;
    logic [16:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.f)
        F_TIME:  act = bus.time_out;
        F_RUN:   act = 17'(bus.running);
        F_ALARM: act = 17'(bus.alarm);
        default: act = 17'(bus.any_alarm);
      endcase
      total++;
      if (act === e.v) passed++;
      else $display("FAIL %s: got %0h expected %0h", e.name, act, e.v);
    end
  end

  function automatic logic [16:0] mk(input int h, input int m, input int s);
    mk = {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input cmd_e c, input int n);
    repeat (n) begin
      case (c)
        C_START: bus.start   = 1'b1;
        C_CLEAR: bus.clear   = 1'b1;
        C_HR:    bus.hr_inc  = 1'b1;
        C_MIN:   bus.min_inc = 1'b1;
        default: bus.sec_inc = 1'b1;
      endcase
      step(1);
      bus.start   = 1'b0;
      bus.clear   = 1'b0;
      bus.hr_inc  = 1'b0;
      bus.min_inc = 1'b0;
      bus.sec_inc = 1'b0;
    end
  endtask

  task automatic align_tick();
    int k = 0;
    while (ph != 9 && k < 20) begin
      step(1);
      k++;
    end
    if (ph != 9) begin
      total++;
      $display("FAIL align_tick: phase %0d expected 9", ph);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      align_tick();
      step(1);
    end
  endtask

  task automatic chk(input string nm, input field_e f, input logic [16:0] v);
    exp_t e;
    e.name = nm;
    e.f    = f;
    e.v    = v;
    q.push_back(e);
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      $display("FAIL sync: %0d checks pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ch_sel  = '0;
    bus.start   = 1'b0;
    bus.clear   = 1'b0;
    bus.hr_inc  = 1'b0;
    bus.min_inc = 1'b0;
    bus.sec_inc = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk("rst_time", F_TIME, '0);
    chk("rst_run", F_RUN, '0);
    chk("rst_alarm", F_ALARM, '0);
    chk("rst_any", F_ANY, '0);
    sync();

    // 1: 00:01:03 countdown to alarm on ch0
    bus.ch_sel = 2'd0;
    pulse(C_SEC, 3);
    pulse(C_MIN, 1);
    chk("t1_set", F_TIME, mk(0, 1, 3));
    sync();
    pulse(C_START, 1);
    chk("t1_run", F_RUN, 17'b0001);
    sync();
    ticks(62);
    chk("t1_time62", F_TIME, mk(0, 0, 1));
    chk("t1_noalarm", F_ALARM, '0);
    chk("t1_still_run", F_RUN, 17'b0001);
    sync();
    ticks(1);
    chk("t1_alarm", F_ALARM, 17'b0001);
    chk("t1_zero", F_TIME, '0);
    chk("t1_any", F_ANY, 17'd1);
    chk("t1_stop", F_RUN, '0);
    sync();

    // 2: field wrap without carry on ch1; zero-time start on ch2
    bus.ch_sel = 2'd1;
    pulse(C_SEC, 61);
    pulse(C_HR, 25);
    pulse(C_MIN, 61);
    chk("t2_wrap", F_TIME, mk(1, 1, 1));
    sync();
    bus.ch_sel = 2'd2;
    pulse(C_START, 1);
    chk("t2_zero_start", F_RUN, '0);
    chk("t2_ch2_time", F_TIME, '0);
    chk("t2_ch0_alarm", F_ALARM, 17'b0001);
    sync();

    // 3: hour borrow, pause and resume on ch0
    bus.ch_sel = 2'd0;
    pulse(C_START, 1);
    chk("t3_ack", F_ALARM, '0);
    sync();
    pulse(C_HR, 1);
    pulse(C_START, 1);
    ticks(1);
    chk("t3_borrow", F_TIME, mk(0, 59, 59));
    chk("t3_run", F_RUN, 17'b0001);
    sync();
    pulse(C_START, 1);
    chk("t3_pause", F_RUN, '0);
    sync();
    ticks(30);
    chk("t3_frozen", F_TIME, mk(0, 59, 59));
    sync();
    pulse(C_START, 1);
    chk("t3_resume", F_RUN, 17'b0001);
    sync();
    ticks(1);
    chk("t3_dec", F_TIME, mk(0, 59, 58));
    sync();

    // 4: start on a tick edge drops only the selected channel's tick
    bus.ch_sel = 2'd3;
    pulse(C_SEC, 5);
    pulse(C_START, 1);
    align_tick();
    pulse(C_START, 1);
    chk("t4_ch3_time", F_TIME, mk(0, 0, 5));
    chk("t4_run", F_RUN, 17'b0001);
    sync();
    bus.ch_sel = 2'd0;
    chk("t4_ch0_dec", F_TIME, mk(0, 59, 57));
    sync();

    // 5: alarm ignores inc, start acknowledges; clear on a running channel
    bus.ch_sel = 2'd2;
    pulse(C_SEC, 2);
    pulse(C_START, 1);
    ticks(2);
    chk("t5_alarm", F_ALARM, 17'b0100);
    chk("t5_any", F_ANY, 17'd1);
    sync();
    pulse(C_SEC, 1);
    chk("t5_inc_ign", F_TIME, '0);
    chk("t5_alarm_held", F_ALARM, 17'b0100);
    sync();
    pulse(C_START, 1);
    chk("t5_ack", F_ALARM, '0);
    chk("t5_any_off", F_ANY, '0);
    chk("t5_run_pre", F_RUN, 17'b0001);
    sync();
    bus.ch_sel = 2'd0;
    pulse(C_CLEAR, 1);
    chk("t5_clr_time", F_TIME, '0);
    chk("t5_clr_run", F_RUN, '0);
    sync();

    // 6: reset mid-run restarts the prescaler
    bus.ch_sel = 2'd1;
    pulse(C_START, 1);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t6_time", F_TIME, '0);
    chk("t6_run", F_RUN, '0);
    chk("t6_alarm", F_ALARM, '0);
    chk("t6_any", F_ANY, '0);
    sync();
    pulse(C_SEC, 2);
    pulse(C_START, 1);
    step(6);
    chk("t6_pre_tick", F_TIME, mk(0, 0, 2));
    chk("t6_running", F_RUN, 17'b0010);
    sync();
    step(1);
    chk("t6_first_tick", F_TIME, mk(0, 0, 1));
    sync();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
